cu_seq: RTL and testbench
=========================

CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 Parameter WIDTH, default 16, data/address/instruction width (min 12).
REQ-002 Parameter OPW, default 6, opcode field width.
REQ-003 Parameter TMO, default 255, max wait cycles on any handshake before fault (1..2^16-1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_b  in  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-006 instr  in  WIDTH  fetched word; opcode = instr[WIDTH-1 -: OPW], imm = instr[WIDTH-OPW-1:0] zero-extended to WIDTH.
REQ-007 instr_valid  in  1  fetch complete, instr valid this cycle.
REQ-008 fetch_req / pc  out  1 / WIDTH  fetch request and program counter.
REQ-009 fl_zero, fl_negative, fl_carry, fl_overflow  in  1 each  ALU flags.
REQ-010 alu_enable / opcode / alu_done  out / out / in  1 / OPW / 1  ALU handshake.
REQ-011 push_req / push_data / push_done  out / out / in  1 / WIDTH / 1  stack push handshake.
REQ-012 pop_req / pop_data / pop_done  out / in / in  1 / WIDTH / 1  stack pop handshake.
REQ-013 halted / error  out  1 each  sticky status.

Function
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC_ALU, EXEC_PUSH, EXEC_POP, HALT, ERROR.
REQ-015 FETCH: fetch_req=1 until instr_valid; on instr_valid, latch instr and go to DECODE next cycle.
REQ-016 DECODE (one cycle): sample flags, dispatch on opcode per REQ-017..REQ-022.
REQ-017 0 NOP: pc<=pc+1 -> FETCH; 1 HLT -> HALT, pc unchanged.
REQ-018 2 BRZ, 3 BRN, 4 BRC, 5 BRO: if fl_zero/fl_negative/fl_carry/fl_overflow respectively =1, pc<=imm, else pc<=pc+1; -> FETCH.
REQ-019 6 JMP: pc<=imm -> FETCH.
REQ-020 7 CALL: push_data=pc+1 -> EXEC_PUSH; on push_done pc<=imm. 9 PUSH: push_data=imm; on push_done pc<=pc+1.
REQ-021 8 RET: -> EXEC_POP; on pop_done pc<=pop_data. 10 POP: on pop_done pc<=pc+1 (data discarded by this block).
REQ-022 Opcodes >=16: -> EXEC_ALU, opcode output = latched opcode, alu_enable=1 until alu_done; then pc<=pc+1 -> FETCH. Opcodes 11..15 SHALL behave as NOP.
REQ-023 Requests (fetch_req, alu_enable, push_req, pop_req) SHALL be level, held until the matching done/valid, deasserted the cycle after it; at most one asserted at a time.
REQ-024 pc arithmetic modulo 2^WIDTH; pc=all-ones +1 wraps to 0 without fault.
REQ-025 Timeout counter clears on entering any wait state (FETCH, EXEC_*), increments each waiting cycle; reaching TMO without done -> ERROR.
REQ-026 done/valid in the same cycle the counter reaches TMO: done wins, no fault.
REQ-027 ERROR: error=1, all requests 0, pc frozen; leaves only via reset. HALT: halted=1, all requests 0; leaves only via reset.
REQ-028 done/valid inputs arriving in a state not waiting for them SHALL be ignored.

Reset
REQ-029 rst_b=1 SHALL immediately (no clock) force state FETCH-pending, pc=0, opcode=0, push_data=0, all requests 0, halted=0, error=0, counter=0.
REQ-030 First fetch_req SHALL assert in the first clk edge after rst_b deasserts; reset mid-handshake abandons the transaction with no pc update.

Verification
REQ-031 Reset, feed NOP at pc 0..2 with instr_valid after 2 cycles each -> pc 0,1,2,3; fetch_req high 3 cycles per fetch.
REQ-032 BRZ imm=0x040 with fl_zero=1 -> pc=0x0040; with fl_zero=0 -> pc=pc+1.
REQ-033 CALL imm=0x100 at pc=0x010 -> push_data=0x0011, push_req until push_done, pc=0x0100; then RET with pop_data=0x0011 -> pc=0x0011.
REQ-034 ALU opcode 0x20, alu_done withheld -> error=1 exactly TMO cycles after alu_enable rose; alu_done on cycle TMO instead -> no error, pc+1.
REQ-035 pc=0xFFFF NOP -> pc=0x0000; HLT -> halted=1, no further fetch_req; rst_b pulse mid-EXEC_ALU -> all outputs zero asynchronously.

Source files
------------

// File: rtl/cu_seq.sv
// cu_seq: fetch/decode/execute sequencer for a small control unit.
// Each handshake (fetch, ALU, push, pop) is a level request that is held
// until its done/valid arrives, guarded by a common timeout counter.
//
// state     | meaning
// ----------+------------------------------------------------------
// FETCH     | fetch_req high until instr_valid, instruction latched
// DECODE    | one cycle: sample flags, update pc or dispatch
// EXEC_ALU  | alu_enable high until alu_done, then pc+1
// EXEC_PUSH | push_req high until push_done (CALL / PUSH)
// EXEC_POP  | pop_req high until pop_done (RET / POP)
// HALT      | halted, no requests, left only by reset
// ERROR     | handshake timed out, pc frozen, left only by reset
module cu_seq #(
  parameter int WIDTH = 16,
  parameter int OPW   = 6,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] instr,
  input  logic             instr_valid,
  output logic             fetch_req,
  output logic [WIDTH-1:0] pc,
  input  logic             fl_zero,
  input  logic             fl_negative,
  input  logic             fl_carry,
  input  logic             fl_overflow,
  output logic             alu_enable,
  output logic [OPW-1:0]   opcode,
  input  logic             alu_done,
  output logic             push_req,
  output logic [WIDTH-1:0] push_data,
  input  logic             push_done,
  output logic             pop_req,
  input  logic [WIDTH-1:0] pop_data,
  input  logic             pop_done,
  output logic             halted,
  output logic             error
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC_ALU, EXEC_PUSH, EXEC_POP, HALT, ERROR
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] push_data_q, push_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Low during reset and for the first edge after it, so fetch_req only
  // rises on the first clock edge following reset release.
  logic             run_q;

  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc_inc;
  logic             waiting;

  assign op     = instr_q[WIDTH-1 -: OPW];
  assign imm    = WIDTH'(instr_q[WIDTH-OPW-1:0]);
  assign pc_inc = pc_q + WIDTH'(1);

  // State, pc, latched instruction, push data and timeout counter registers
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      push_data_q <= '0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      push_data_q <= push_data_d;
      cnt_q       <= cnt_d;
      run_q       <= 1'b1;
    end
  end

  // Next-state, pc update and timeout logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    push_data_d = push_data_q;
    cnt_d       = cnt_q;
    waiting     = 1'b0;

    case (state_q)
      FETCH: begin
        if (run_q) begin
          if (instr_valid) begin
            instr_d = instr;
            state_d = DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      DECODE: begin
        if (op >= OPW'(16)) begin
          state_d = EXEC_ALU;
        end else begin
          state_d = FETCH;
          pc_d    = pc_inc;
          case (op)
            OPW'(1): begin
              state_d = HALT;
              pc_d    = pc_q;
            end
            OPW'(2): if (fl_zero)     pc_d = imm;
            OPW'(3): if (fl_negative) pc_d = imm;
            OPW'(4): if (fl_carry)    pc_d = imm;
            OPW'(5): if (fl_overflow) pc_d = imm;
            OPW'(6): pc_d = imm;
            OPW'(7): begin
              pc_d        = pc_q;
              push_data_d = pc_inc;
              state_d     = EXEC_PUSH;
            end
            OPW'(8): begin
              pc_d    = pc_q;
              state_d = EXEC_POP;
            end
            OPW'(9): begin
              pc_d        = pc_q;
              push_data_d = imm;
              state_d     = EXEC_PUSH;
            end
            OPW'(10): begin
              pc_d    = pc_q;
              state_d = EXEC_POP;
            end
            default: ;
          endcase
        end
      end
      EXEC_ALU: begin
        if (alu_done) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      EXEC_PUSH: begin
        if (push_done) begin
          pc_d    = (op == OPW'(7)) ? imm : pc_inc;
          state_d = FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      EXEC_POP: begin
        if (pop_done) begin
          pc_d    = (op == OPW'(8)) ? pop_data : pc_inc;
          state_d = FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      default: ;
    endcase

    // A done arriving on the last allowed cycle takes the branch above,
    // so it always beats the timeout.
    if (waiting) begin
      if (cnt_q == TMO_LAST) state_d = ERROR;
      else                   cnt_d   = cnt_q + CW'(1);
    end

    if (state_d != state_q) cnt_d = '0;
  end

  assign fetch_req  = (state_q == FETCH) && run_q;
  assign alu_enable = (state_q == EXEC_ALU);
  assign push_req   = (state_q == EXEC_PUSH);
  assign pop_req    = (state_q == EXEC_POP);
  assign halted     = (state_q == HALT);
  assign error      = (state_q == ERROR);
  assign pc         = pc_q;
  assign opcode     = op;
  assign push_data  = push_data_q;

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: directed table-driven bench for cu_seq with hand sequences
// for stack handshakes, timeout, wrap, halt and async reset.
module tb_cu_seq;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        fetch_req;
  logic [15:0] pc;
  logic        fl_zero = 1'b0, fl_negative = 1'b0, fl_carry = 1'b0, fl_overflow = 1'b0;
  logic        alu_enable;
  logic [5:0]  opcode;
  logic        alu_done = 1'b0;
  logic        push_req;
  logic [15:0] push_data;
  logic        push_done = 1'b0;
  logic        pop_req;
  logic [15:0] pop_data = '0;
  logic        pop_done = 1'b0;
  logic        halted, error;

  int n_pass = 0;
  int n_total = 0;

  cu_seq dut (
    .clk(clk), .rst_b(rst_b), .instr(instr), .instr_valid(instr_valid),
    .fetch_req(fetch_req), .pc(pc),
    .fl_zero(fl_zero), .fl_negative(fl_negative), .fl_carry(fl_carry), .fl_overflow(fl_overflow),
    .alu_enable(alu_enable), .opcode(opcode), .alu_done(alu_done),
    .push_req(push_req), .push_data(push_data), .push_done(push_done),
    .pop_req(pop_req), .pop_data(pop_data), .pop_done(pop_done),
    .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [3:0]  fl;   // {zero, negative, carry, overflow}
    int          dly;
    logic [15:0] pc;
  } vec_t;

  vec_t vt[14];

  function automatic logic [15:0] mk(input int op, input int imm);
    logic [5:0] o;
    logic [9:0] i;
    o = op[5:0];
    i = imm[9:0];
    return {o, i};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Hold reset, check the reset state, release between edges and check
  // that fetch_req rises on the first edge afterwards.
  task automatic do_reset;
    rst_b = 1'b1;
    instr_valid = 1'b0; alu_done = 1'b0; push_done = 1'b0; pop_done = 1'b0;
    {fl_zero, fl_negative, fl_carry, fl_overflow} = 4'b0;
    #2;
    chk("rst_outputs",
        {16'(pc), 10'(push_data), 6'(opcode)}, 32'h0);
    chk("rst_ctrl", {fetch_req, alu_enable, push_req, pop_req, halted, error}, 6'b0);
    @(negedge clk);
    rst_b = 1'b0;
    step;
    chk("first_fetch_req", fetch_req, 1'b1);
  endtask

  // Serve one fetch: instr_valid after dly cycles; returns fetch_req cycles.
  task automatic fetch(input logic [15:0] w, input int dly, output int frc);
    int guard;
    guard = 0;
    while (!fetch_req && guard < 20) begin
      step;
      guard++;
    end
    if (!fetch_req) begin
      n_total++;
      $display("FAIL fetch_wait: fetch_req never rose (got 0 expected 1)");
    end
    frc = 0;
    for (int i = 0; i <= dly; i++) begin
      if (i == dly) begin
        instr = w;
        instr_valid = 1'b1;
      end
      if (fetch_req) frc++;
      step;
    end
    instr_valid = 1'b0;
  endtask

  // Fetch and decode a single-cycle instruction with the given flags.
  task automatic run_simple(input logic [15:0] w, input logic [3:0] fl, input int dly, output int frc);
    fetch(w, dly, frc);
    {fl_zero, fl_negative, fl_carry, fl_overflow} = fl;
    step;
    {fl_zero, fl_negative, fl_carry, fl_overflow} = 4'b0;
  endtask

  initial begin
    int frc;
    vt[0]  = '{mk(0, 0),      4'b0000, 2, 16'h0001};
    vt[1]  = '{mk(0, 0),      4'b0000, 2, 16'h0002};
    vt[2]  = '{mk(0, 0),      4'b0000, 2, 16'h0003};
    vt[3]  = '{mk(2, 'h040),  4'b1000, 0, 16'h0040};
    vt[4]  = '{mk(2, 'h040),  4'b0111, 1, 16'h0041};
    vt[5]  = '{mk(3, 'h080),  4'b0100, 0, 16'h0080};
    vt[6]  = '{mk(3, 'h080),  4'b1011, 3, 16'h0081};
    vt[7]  = '{mk(4, 'h0C0),  4'b0010, 0, 16'h00C0};
    vt[8]  = '{mk(5, 'h123),  4'b0001, 1, 16'h0123};
    vt[9]  = '{mk(5, 'h200),  4'b1110, 0, 16'h0124};
    vt[10] = '{mk(6, 'h010),  4'b0000, 0, 16'h0010};
    vt[11] = '{mk(11, 'h3FF), 4'b1111, 0, 16'h0011};
    vt[12] = '{mk(15, 'h3FF), 4'b1111, 2, 16'h0012};
    vt[13] = '{mk(6, 'h010),  4'b0000, 0, 16'h0010};

    do_reset;

    for (int k = 0; k < 14; k++) begin
      run_simple(vt[k].w, vt[k].fl, vt[k].dly, frc);
      chk($sformatf("vec%0d_pc", k), pc, vt[k].pc);
      chk($sformatf("vec%0d_frc", k), frc, vt[k].dly + 1);
      chk($sformatf("vec%0d_back_fetch", k), fetch_req, 1'b1);
    end

    // CALL 0x100 at pc 0x010; a stray pop_done must be ignored.
    fetch(mk(7, 'h100), 0, frc);
    step;
    chk("call_push_req", {push_req, fetch_req, pop_req, alu_enable}, 4'b1000);
    chk("call_push_data", push_data, 16'h0011);
    chk("call_pc_hold", pc, 16'h0010);
    pop_done = 1'b1; alu_done = 1'b1;
    step;
    pop_done = 1'b0; alu_done = 1'b0;
    step;
    chk("call_push_held", push_req, 1'b1);
    push_done = 1'b1;
    step;
    push_done = 1'b0;
    chk("call_done_ctrl", {push_req, fetch_req}, 2'b01);
    chk("call_pc", pc, 16'h0100);

    // RET with pop_data 0x0011.
    fetch(mk(8, 0), 1, frc);
    step;
    chk("ret_pop_req", {pop_req, push_req, fetch_req}, 3'b100);
    step;
    pop_data = 16'h0011; pop_done = 1'b1;
    step;
    pop_done = 1'b0;
    chk("ret_pc", pc, 16'h0011);
    chk("ret_pop_drop", pop_req, 1'b0);

    // PUSH imm 0x2AB, then POP with data discarded.
    fetch(mk(9, 'h2AB), 0, frc);
    step;
    chk("push_data", push_data, 16'h02AB);
    push_done = 1'b1;
    step;
    push_done = 1'b0;
    chk("push_pc", pc, 16'h0012);
    fetch(mk(10, 0), 0, frc);
    step;
    pop_data = 16'hBEEF; pop_done = 1'b1;
    step;
    pop_done = 1'b0;
    chk("pop_pc", pc, 16'h0013);

    // ALU op with alu_done on the last allowed cycle: no fault.
    fetch(mk('h20, 5), 0, frc);
    step;
    chk("alu_enable", alu_enable, 1'b1);
    chk("alu_opcode", opcode, 6'h20);
    repeat (TMO - 1) step;
    chk("alu_no_err_early", error, 1'b0);
    alu_done = 1'b1;
    step;
    alu_done = 1'b0;
    chk("alu_late_done", {error, alu_enable, fetch_req}, 3'b001);
    chk("alu_pc", pc, 16'h0014);

    // pc wrap: RET to 0xFFFF then NOP.
    fetch(mk(8, 0), 0, frc);
    step;
    pop_data = 16'hFFFF; pop_done = 1'b1;
    step;
    pop_done = 1'b0;
    chk("ret_ffff", pc, 16'hFFFF);
    run_simple(mk(0, 0), 4'b0, 0, frc);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_no_err", error, 1'b0);

    // ALU timeout: error exactly TMO cycles after alu_enable rose.
    fetch(mk('h21, 0), 0, frc);
    step;
    repeat (TMO - 1) step;
    chk("tmo_not_yet", {error, alu_enable}, 2'b01);
    step;
    chk("tmo_error", {error, alu_enable, fetch_req}, 3'b100);
    instr_valid = 1'b1; alu_done = 1'b1; push_done = 1'b1; pop_done = 1'b1;
    repeat (3) step;
    instr_valid = 1'b0; alu_done = 1'b0; push_done = 1'b0; pop_done = 1'b0;
    chk("tmo_sticky", {error, fetch_req, push_req, pop_req, alu_enable}, 5'b10000);
    chk("tmo_pc_frozen", pc, 16'h0000);

    // HLT: halted sticky, no further fetch_req.
    do_reset;
    run_simple(mk(1, 0), 4'b0, 1, frc);
    chk("hlt_halted", {halted, error}, 2'b10);
    chk("hlt_pc", pc, 16'h0000);
    frc = 0;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (fetch_req) frc++;
      step;
    end
    instr_valid = 1'b0;
    chk("hlt_no_fetch", frc, 0);
    chk("hlt_sticky", halted, 1'b1);

    // Async reset in the middle of EXEC_ALU.
    do_reset;
    run_simple(mk(6, 'h055), 4'b0, 0, frc);
    run_simple(mk(9, 'h155), 4'b0, 0, frc);
    push_done = 1'b1;
    step;
    push_done = 1'b0;
    chk("pre_rst_pc", pc, 16'h0056);
    fetch(mk('h30, 0), 0, frc);
    step;
    chk("pre_rst_alu", {alu_enable, opcode}, {1'b1, 6'h30});
    #2;
    rst_b = 1'b1;
    #1;
    chk("async_rst_data", {pc, push_data}, 32'h0);
    chk("async_rst_ctrl", {fetch_req, alu_enable, push_req, pop_req, halted, error, opcode}, 12'h0);
    @(negedge clk);
    rst_b = 1'b0;
    step;
    chk("post_rst_fetch", {fetch_req, alu_enable}, 2'b10);
    chk("post_rst_pc", pc, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout expected finish)");
    $fatal(1);
  end

endmodule
